// File: rtl/mult_rr_sched_if.sv
// Request/grant/result bundle between the two clients and the shared multiplier scheduler.
interface mult_rr_sched_if #(parameter int W = 8);
  logic         req0;
  logic [W-1:0] a0;
  logic [W-1:0] b0;
  logic         req1;
  logic [W-1:0] a1;
  logic [W-1:0] b1;
  logic         gnt0;
  logic         gnt1;
  logic         busy;
  logic         done;
  logic         id;
  logic [W-1:0] s;
  logic         ov;

  modport master (
    output req0, a0, b0, req1, a1, b1,
    input  gnt0, gnt1, busy, done, id, s, ov
  );

  modport slave (
    input  req0, a0, b0, req1, a1, b1,
    output gnt0, gnt1, busy, done, id, s, ov
  );
endinterface

// File: rtl/mult_rr_sched.sv
// Round-robin scheduler sharing one shift-add multiplier (one multiplier bit per clock)
// between two requesters; reports low-W product, overflow and owner with a DONE pulse.
module mult_rr_sched #(
  parameter int W = 8
) (
  input  logic          clk,
  input  logic          rst,
  mult_rr_sched_if.slave bus
);
  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t         state, state_n;
  logic [W-1:0]   areg, breg;
  logic [CW-1:0]  cnt;
  logic [2*W-1:0] acc, acc_sum, a_ext;
  logic           own, last;
  logic           gnt0_q, gnt1_q, busy_q, done_q, id_q, ov_q;
  logic [W-1:0]   s_q;

  logic grant, win, last_step;
  logic gnt0_n, gnt1_n, busy_n, done_n;

  // Tie goes to whoever was not granted last
  assign win       = (bus.req0 && bus.req1) ? ~last : bus.req1;
  assign last_step = (cnt == CW'(W - 1));
  assign a_ext     = {{W{1'b0}}, areg};
  assign acc_sum   = breg[cnt] ? (acc + (a_ext << cnt)) : acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:  if (bus.req0 || bus.req1) state_n = S_RUN;
      S_RUN:   if (last_step) state_n = S_DONE;
      default: state_n = S_IDLE;
    endcase
  end

  // Next values of the registered outputs
  always_comb begin
    grant  = (state == S_IDLE) && (bus.req0 || bus.req1);
    gnt0_n = grant && !win;
    gnt1_n = grant && win;
    done_n = (state == S_RUN) && last_step;
    busy_n = (state_n != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      areg   <= '0;
      breg   <= '0;
      cnt    <= '0;
      acc    <= '0;
      own    <= 1'b0;
      last   <= 1'b1;
      gnt0_q <= 1'b0;
      gnt1_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      id_q   <= 1'b0;
      s_q    <= '0;
      ov_q   <= 1'b0;
    end else begin
      gnt0_q <= gnt0_n;
      gnt1_q <= gnt1_n;
      busy_q <= busy_n;
      done_q <= done_n;
      if (grant) begin
        areg <= win ? bus.a1 : bus.a0;
        breg <= win ? bus.b1 : bus.b0;
        cnt  <= '0;
        acc  <= '0;
        own  <= win;
        last <= win;
      end
      if (state == S_RUN) begin
        acc <= acc_sum;
        cnt <= cnt + CW'(1);
        // The final partial product is folded in through acc_sum, not the stale acc
        if (last_step) begin
          s_q  <= acc_sum[W-1:0];
          ov_q <= |acc_sum[2*W-1:W];
          id_q <= own;
        end
      end
    end
  end

  assign bus.gnt0 = gnt0_q;
  assign bus.gnt1 = gnt1_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.id   = id_q;
  assign bus.s    = s_q;
  assign bus.ov   = ov_q;
endmodule

// File: tb/tb_mult_rr_sched.sv
// Bench for mult_rr_sched: directed vector table and corner sequences plus random
// traffic, all scored against a transaction-level arbitration/product model.
module tb_mult_rr_sched;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;

  mult_rr_sched_if #(.W(W)) bus ();
  mult_rr_sched #(.W(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: operations as whole transactions, due W cycles after grant
  typedef struct {
    logic [W-1:0] s;
    logic         ov;
    logic         id;
    int           due;
  } exp_t;

  exp_t pend[$];
  exp_t held;
  int   cyc = 0;
  int   next_ok;
  int   busy_until;
  logic last_m;

  task automatic model_reset();
    pend.delete();
    held.s = '0; held.ov = 1'b0; held.id = 1'b0; held.due = 0;
    last_m = 1'b1;
    next_ok = 0;
    busy_until = -1;
  endtask

  always @(negedge clk) begin
    bit   want, win;
    int   p;
    exp_t e;
    cyc++;
    if (!rst) begin
      want = (cyc >= next_ok) && (bus.req0 || bus.req1);
      win  = (bus.req0 && bus.req1) ? ~last_m : bus.req1;
      chk("gnt0", bus.gnt0, want && !win);
      chk("gnt1", bus.gnt1, want && win);
      if (want) begin
        last_m = win;
        next_ok = cyc + W + 2;
        busy_until = cyc + W;
        p = win ? int'(bus.a1) * int'(bus.b1) : int'(bus.a0) * int'(bus.b0);
        e.s = p[W-1:0];
        e.ov = (p >= (1 << W));
        e.id = win;
        e.due = cyc + W;
        pend.push_back(e);
      end
      chk("busy", bus.busy, cyc <= busy_until);
      if (pend.size() > 0 && pend[0].due == cyc) begin
        chk("done", bus.done, 1);
        held = pend.pop_front();
      end else begin
        chk("done", bus.done, 0);
      end
      chk("s", bus.s, held.s);
      chk("ov", bus.ov, held.ov);
      chk("id", bus.id, held.id);
    end
  end

  task automatic check_zero(input string nm);
    chk({nm, "_gnt0"}, bus.gnt0, 0);
    chk({nm, "_gnt1"}, bus.gnt1, 0);
    chk({nm, "_busy"}, bus.busy, 0);
    chk({nm, "_done"}, bus.done, 0);
    chk({nm, "_id"}, bus.id, 0);
    chk({nm, "_s"}, bus.s, 0);
    chk({nm, "_ov"}, bus.ov, 0);
  endtask

  task automatic do_reset(input string nm);
    @(negedge clk); #1;
    rst = 1'b1;
    #1;
    check_zero(nm);
    model_reset();
    @(negedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic op(input bit who, input logic [W-1:0] a, input logic [W-1:0] b,
                    input logic [W-1:0] es, input bit eov, input bit scramble, input string nm);
    int k;
    bit got;
    @(negedge clk); #1;
    if (who) begin bus.req1 = 1'b1; bus.a1 = a; bus.b1 = b; end
    else     begin bus.req0 = 1'b1; bus.a0 = a; bus.b0 = b; end
    got = 0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk); #1;
      got = who ? bus.gnt1 : bus.gnt0;
    end
    chk({nm, "_gnt"}, got, 1);
    if (who) bus.req1 = 1'b0; else bus.req0 = 1'b0;
    got = 0;
    k = 0;
    for (int i = 0; i < 30 && !got; i++) begin
      if (scramble) begin
        bus.a0 = W'($urandom); bus.b0 = W'($urandom);
      end
      @(negedge clk); #1;
      k++;
      got = bus.done;
    end
    chk({nm, "_done"}, got, 1);
    chk({nm, "_lat"}, k, W);
    chk({nm, "_s"}, bus.s, es);
    chk({nm, "_ov"}, bus.ov, eov);
    chk({nm, "_id"}, bus.id, who);
  endtask

  typedef struct {
    bit           who;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] s;
    bit           ov;
  } vec_t;

  initial begin
    vec_t vt[6];
    int   order[$];
    int   dres[$];
    bit   got;

    rst = 1'b1;
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.a0 = '0; bus.b0 = '0; bus.a1 = '0; bus.b1 = '0;
    model_reset();

    vt[0] = '{who: 1'b0, a: 8'd12,  b: 8'd10,  s: 8'd120, ov: 1'b0};
    vt[1] = '{who: 1'b1, a: 8'd20,  b: 8'd15,  s: 8'h2C,  ov: 1'b1};
    vt[2] = '{who: 1'b0, a: 8'd255, b: 8'd255, s: 8'h01,  ov: 1'b1};
    vt[3] = '{who: 1'b1, a: 8'd0,   b: 8'd200, s: 8'd0,   ov: 1'b0};
    vt[4] = '{who: 1'b0, a: 8'd1,   b: 8'd255, s: 8'd255, ov: 1'b0};
    vt[5] = '{who: 1'b1, a: 8'd128, b: 8'd2,   s: 8'd0,   ov: 1'b1};

    repeat (3) @(negedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;

    foreach (vt[i]) op(vt[i].who, vt[i].a, vt[i].b, vt[i].s, vt[i].ov, 1'b0, $sformatf("vec%0d", i));

    // Contention: both requesters held across reset
    @(negedge clk); #1;
    bus.req0 = 1'b1; bus.a0 = 8'd3; bus.b0 = 8'd5;
    bus.req1 = 1'b1; bus.a1 = 8'd7; bus.b1 = 8'd9;
    do_reset("rst2");
    for (int i = 0; i < 80 && dres.size() < 8; i++) begin
      @(negedge clk); #1;
      if (bus.gnt0) order.push_back(0);
      if (bus.gnt1) order.push_back(1);
      if (bus.done) begin dres.push_back(int'(bus.s)); dres.push_back(int'(bus.id)); end
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    chk("cont_ngrants", order.size(), 4);
    chk("cont_ndone", dres.size(), 8);
    for (int i = 0; i < 4; i++) begin
      if (i < order.size()) chk($sformatf("cont_order%0d", i), order[i], i % 2);
      if (2 * i + 1 < dres.size()) begin
        chk($sformatf("cont_s%0d", i), dres[2*i], (i % 2) ? 63 : 15);
        chk($sformatf("cont_id%0d", i), dres[2*i+1], i % 2);
      end
    end
    repeat (2) @(negedge clk);

    // Abort in the middle of RUN
    #1;
    bus.req0 = 1'b1; bus.a0 = 8'd20; bus.b0 = 8'd15;
    got = 0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk); #1;
      got = bus.gnt0;
    end
    chk("abort_gnt", got, 1);
    bus.req0 = 1'b0;
    repeat (3) @(negedge clk);
    do_reset("abort");
    repeat (12) @(negedge clk);
    op(1'b1, 8'd2, 8'd3, 8'd6, 1'b0, 1'b0, "post_abort");
    @(negedge clk); #1;
    bus.req0 = 1'b1; bus.a0 = 8'd3; bus.b0 = 8'd5;
    bus.req1 = 1'b1; bus.a1 = 8'd7; bus.b1 = 8'd9;
    got = 0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk); #1;
      got = bus.gnt0 || bus.gnt1;
      if (got) chk("tie_winner0", bus.gnt0, 1);
    end
    chk("tie_gnt", got, 1);
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    repeat (W + 3) @(negedge clk);

    // Operands wiggled after grant must not disturb the captured product
    op(1'b0, 8'd13, 8'd17, 8'd221, 1'b0, 1'b1, "opchg");

    // Random traffic obeying the hold-until-grant rule
    for (int i = 0; i < 400; i++) begin
      @(negedge clk); #1;
      if (bus.gnt0) bus.req0 = 1'b0;
      if (bus.gnt1) bus.req1 = 1'b0;
      if (!bus.req0) begin
        bus.a0 = W'($urandom); bus.b0 = W'($urandom);
        if ($urandom_range(3) == 0) bus.req0 = 1'b1;
      end
      if (!bus.req1) begin
        bus.a1 = W'($urandom); bus.b1 = W'($urandom);
        if ($urandom_range(3) == 0) bus.req1 = 1'b1;
      end
    end
    @(negedge clk); #1;
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    repeat (2 * W + 4) @(negedge clk);
    chk("drain", pend.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
